// File: rtl/vga_timing_gen_if.sv
// VGA raster bundle: counters, blank, frame strobe, syncs.
// master = timing generator, slave = renderers / DAC.
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       frame_start;
  logic       hs;
  logic       vs;

  modport master (
    output DrawX, DrawY, blank,
    output frame_start, hs, vs
  );
  modport slave (
    input DrawX, DrawY, blank,
    input frame_start, hs, vs
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clk vga_clk, sync reset, pixel_ce in;
// DrawX/DrawY/blank/frame_start/hs/vs out via vga (master).
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic pixel_ce,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL =
    H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_VISIBLE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL > 1024) || (V_TOTAL > 1024) ||
      (SYNC_DELAY > 4) || (SYNC_DELAY < 0))
  begin : g_bad_cfg
    $error("vga_timing_gen: bad parameters");
  end

  localparam logic [9:0] H_LAST =
    10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST =
    10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS =
    11'(H_VISIBLE);
  localparam logic [10:0] V_VIS =
    11'(V_VISIBLE);
  localparam logic [10:0] H_SS =
    11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SE =
    11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_SS =
    11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SE =
    11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] x_q, y_q;
  logic [9:0] x_n, y_n;
  logic       blank_q, fs_q;
  logic       blank_n, fs_n;
  logic       hs_n, vs_n;
  logic [SYNC_DELAY:0] hs_q, vs_q;

  // Everything registered from the next count, so the
  // flags change on the same edge as DrawX/DrawY.
  always_comb begin
    x_n = x_q + 10'd1;
    y_n = y_q;
    if (x_q == H_LAST) begin
      x_n = '0;
      y_n = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
    blank_n = ({1'b0, x_n} < H_VIS) &&
              ({1'b0, y_n} < V_VIS);
    fs_n = (x_n == '0) && (y_n == '0);
    hs_n = !(({1'b0, x_n} >= H_SS) &&
             ({1'b0, x_n} <  H_SE));
    vs_n = !(({1'b0, y_n} >= V_SS) &&
             ({1'b0, y_n} <  V_SE));
  end

  // Stage 0 holds the raw sync; stage SYNC_DELAY drives
  // the pin. Reset fills every stage so no partial pulse
  // survives a mid-frame reset.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q     <= H_LAST;
      y_q     <= V_LAST;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      hs_q    <= '1;
      vs_q    <= '1;
    end else if (pixel_ce) begin
      x_q     <= x_n;
      y_q     <= y_n;
      blank_q <= blank_n;
      fs_q    <= fs_n;
      hs_q[0] <= hs_n;
      vs_q[0] <= vs_n;
      for (int i = 1; i <= SYNC_DELAY; i++) begin
        hs_q[i] <= hs_q[i-1];
        vs_q[i] <= vs_q[i-1];
      end
    end
  end

  assign vga.DrawX       = x_q;
  assign vga.DrawY       = y_q;
  assign vga.blank       = blank_q;
  assign vga.frame_start = fs_q;
  assign vga.hs          = hs_q[SYNC_DELAY];
  assign vga.vs          = vs_q[SYNC_DELAY];

endmodule
